// File: rtl/generador_flancos_pkg.sv
// generador_flancos_pkg
// Shared definitions for the pulse-train generator: FSM state encoding and
// the default counter width used by the interface, the top and the counters.
package generador_flancos_pkg;

  // Default width of the operand inputs and of both internal counters.
  localparam int CNT_W_DEF = 8;

  // Generator states. The wave output is high exactly while in ST_HIGH.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } estado_t;

endpackage

// File: rtl/generador_flancos_if.sv
// generador_flancos_if
// Groups the control/operand inputs and the waveform/strobe outputs of the
// pulse-train generator.
//   iStart, iStop                  : start request / abort request
//   iHighTime, iLowTime, iNumPulses : train operands (CNT_W bits)
//   oWave                          : generated waveform
//   oRise, oFall                   : one-cycle strobes on oWave transitions
//   oBusy, oDone                   : train in progress / normal completion
// Modport slave is the generator, modport master is whoever drives it.
interface generador_flancos_if
  import generador_flancos_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) ();

  logic             iStart;
  logic             iStop;
  logic [CNT_W-1:0] iHighTime;
  logic [CNT_W-1:0] iLowTime;
  logic [CNT_W-1:0] iNumPulses;
  logic             oWave;
  logic             oRise;
  logic             oFall;
  logic             oBusy;
  logic             oDone;

  modport master (
    output iStart, iStop, iHighTime, iLowTime, iNumPulses,
    input  oWave, oRise, oFall, oBusy, oDone
  );

  modport slave (
    input  iStart, iStop, iHighTime, iLowTime, iNumPulses,
    output oWave, oRise, oFall, oBusy, oDone
  );

endinterface

// File: rtl/generador_flancos_contador_fase.sv
// contador_fase
// Loadable down-counter with a zero flag. Used by the generator both as the
// phase counter (cycles left in the current high/low phase) and as the pulse
// counter (pulses left after the current one).
//   iClk, iReset  : clock, synchronous active-high reset (clears the count)
//   load_i        : load loadValue_i this cycle (has priority over enable)
//   loadValue_i   : value to load
//   enable_i      : decrement by one
//   zero_o        : count is zero
module contador_fase
  import generador_flancos_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             iClk,
  input  logic             iReset,
  input  logic             load_i,
  input  logic [CNT_W-1:0] loadValue_i,
  input  logic             enable_i,
  output logic             zero_o
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] countQ;
  logic [CNT_W-1:0] countD;

  // Load wins over decrement; the count saturates at zero so it can never wrap.
  always_comb begin
    countD = countQ;
    if (load_i) begin
      countD = loadValue_i;
    end else if (enable_i && (countQ != '0)) begin
      countD = countQ - ONE;
    end
  end

  always_ff @(posedge iClk) begin
    if (iReset) begin
      countQ <= '0;
    end else begin
      countQ <= countD;
    end
  end

  assign zero_o = (countQ == '0);

endmodule

// File: rtl/generador_flancos.sv
// generador_flancos
// Programmable pulse-train generator. A start strobe in IDLE launches N high
// pulses of H cycles separated by gaps of L cycles (0 is treated as 1 for H
// and L); every output is registered, so the first rising edge appears the
// cycle after the start is sampled.
//   iClk    : system clock
//   iReset  : synchronous, active-high reset
//   bus     : generador_flancos_if.slave (start/stop, operands, wave, strobes)
module generador_flancos
  import generador_flancos_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input logic                iClk,
  input logic                iReset,
  generador_flancos_if.slave bus
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  estado_t          stateQ, stateD;
  logic [CNT_W-1:0] highQ, highD;
  logic [CNT_W-1:0] lowQ, lowD;

  logic             phaseLoad, phaseEn, phaseZero;
  logic [CNT_W-1:0] phaseLoadVal;
  logic             pulseLoad, pulseEn, pulseZero;
  logic [CNT_W-1:0] pulseLoadVal;

  logic waveQ, waveD;
  logic riseQ, riseD;
  logic fallQ, fallD;
  logic busyQ, busyD;
  logic doneQ, doneD;

  contador_fase #(.CNT_W(CNT_W)) uPhase (
    .iClk        (iClk),
    .iReset      (iReset),
    .load_i      (phaseLoad),
    .loadValue_i (phaseLoadVal),
    .enable_i    (phaseEn),
    .zero_o      (phaseZero)
  );

  contador_fase #(.CNT_W(CNT_W)) uPulse (
    .iClk        (iClk),
    .iReset      (iReset),
    .load_i      (pulseLoad),
    .loadValue_i (pulseLoadVal),
    .enable_i    (pulseEn),
    .zero_o      (pulseZero)
  );

  // State, latched operands and the registered outputs.
  always_ff @(posedge iClk) begin
    if (iReset) begin
      stateQ <= ST_IDLE;
      highQ  <= '0;
      lowQ   <= '0;
      waveQ  <= 1'b0;
      riseQ  <= 1'b0;
      fallQ  <= 1'b0;
      busyQ  <= 1'b0;
      doneQ  <= 1'b0;
    end else begin
      stateQ <= stateD;
      highQ  <= highD;
      lowQ   <= lowD;
      waveQ  <= waveD;
      riseQ  <= riseD;
      fallQ  <= fallD;
      busyQ  <= busyD;
      doneQ  <= doneD;
    end
  end

  // Next state and counter control. Operands are only captured on an accepted
  // start, so input changes during a train are invisible. A phase counter at
  // zero means the current cycle is the last one of that phase; the pulse
  // counter at zero means the current high phase is the final pulse.
  always_comb begin
    stateD       = stateQ;
    highD        = highQ;
    lowD         = lowQ;
    phaseLoad    = 1'b0;
    phaseLoadVal = '0;
    phaseEn      = 1'b0;
    pulseLoad    = 1'b0;
    pulseLoadVal = '0;
    pulseEn      = 1'b0;
    case (stateQ)
      ST_IDLE: begin
        if (bus.iStart && !bus.iStop && (bus.iNumPulses != '0)) begin
          highD        = (bus.iHighTime == '0) ? ONE : bus.iHighTime;
          lowD         = (bus.iLowTime == '0) ? ONE : bus.iLowTime;
          phaseLoad    = 1'b1;
          phaseLoadVal = highD - ONE;
          pulseLoad    = 1'b1;
          pulseLoadVal = bus.iNumPulses - ONE;
          stateD       = ST_HIGH;
        end
      end
      ST_HIGH: begin
        if (bus.iStop) begin
          stateD = ST_IDLE;
        end else if (phaseZero) begin
          if (pulseZero) begin
            stateD = ST_IDLE;
          end else begin
            phaseLoad    = 1'b1;
            phaseLoadVal = lowQ - ONE;
            stateD       = ST_LOW;
          end
        end else begin
          phaseEn = 1'b1;
        end
      end
      ST_LOW: begin
        if (bus.iStop) begin
          stateD = ST_IDLE;
        end else if (phaseZero) begin
          pulseEn      = 1'b1;
          phaseLoad    = 1'b1;
          phaseLoadVal = highQ - ONE;
          stateD       = ST_HIGH;
        end else begin
          phaseEn = 1'b1;
        end
      end
      default: begin
        stateD = ST_IDLE;
      end
    endcase
  end

  // Output decode from the transition being taken, so the registered outputs
  // line up with the state they describe. Leaving HIGH for IDLE without a stop
  // can only be the end of the last pulse, which is what marks completion.
  always_comb begin
    waveD = (stateD == ST_HIGH);
    busyD = (stateD != ST_IDLE);
    riseD = (stateD == ST_HIGH) && (stateQ != ST_HIGH);
    fallD = (stateQ == ST_HIGH) && (stateD != ST_HIGH);
    doneD = (stateQ == ST_HIGH) && (stateD == ST_IDLE) && !bus.iStop;
  end

  assign bus.oWave = waveQ;
  assign bus.oRise = riseQ;
  assign bus.oFall = fallQ;
  assign bus.oBusy = busyQ;
  assign bus.oDone = doneQ;

endmodule

// File: tb/tb_generador_flancos.sv
// tb_generador_flancos
// Self-checking bench for generador_flancos: directed reset/abort/busy/reset
// sequences, a table of trains with hand-computed lengths and edge counts, and
// randomized trains compared cycle by cycle against an arithmetic model of the
// waveform.
module tb_generador_flancos;
  import generador_flancos_pkg::*;

  localparam int W = CNT_W_DEF;

  logic iClk = 1'b0;
  logic iReset;

  generador_flancos_if #(.CNT_W(W)) bus ();

  generador_flancos #(.CNT_W(W)) dut (
    .iClk   (iClk),
    .iReset (iReset),
    .bus    (bus)
  );

  always #5 iClk = ~iClk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int h;
    int l;
    int n;
    int expFirst;
    int expLen;
    int expRises;
    int expFalls;
  } vec_t;

  // Output vector order: {wave, rise, fall, busy, done}.
  task automatic checkOutput(input string name, input int t, input logic [4:0] got, input logic [4:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s t=%0d actual={w,r,f,b,d}=%b required=%b", name, t, got, exp);
    end
  endtask

  task automatic checkValue(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  function automatic logic [4:0] sampleOut();
    return {bus.oWave, bus.oRise, bus.oFall, bus.oBusy, bus.oDone};
  endfunction

  function automatic int effW(input int v);
    return (v == 0) ? 1 : v;
  endfunction

  // Cycles from the first rise to the last high cycle inclusive.
  function automatic int trainLen(input int h, input int l, input int n);
    if (n == 0) return 0;
    return n * effW(h) + (n - 1) * effW(l);
  endfunction

  // Expected outputs t cycles after the start was sampled (t=1 is the first
  // high cycle). stopAt is the cycle during which iStop is held (0 = none).
  function automatic logic [4:0] refOut(input int h, input int l, input int n, input int t, input int stopAt);
    int hh, ll, T, r;
    logic waveAtStop;
    hh = effW(h);
    ll = effW(l);
    T  = trainLen(h, l, n);
    if (n == 0 || t < 1) return 5'b00000;
    if (stopAt >= 1 && stopAt <= T && t > stopAt) begin
      waveAtStop = (((stopAt - 1) % (hh + ll)) < hh);
      if (t == stopAt + 1) return {2'b00, waveAtStop, 2'b00};
      return 5'b00000;
    end
    if (t <= T) begin
      r = (t - 1) % (hh + ll);
      return {(r < hh), (r == 0), (r == hh), 1'b1, 1'b0};
    end
    if (t == T + 1) return 5'b00101;
    return 5'b00000;
  endfunction

  // Launches one train and checks every cycle against the model. mode 1
  // scribbles random inputs while busy; mode 2 retriggers with H=1 at t=2.
  task automatic applyStimulus(input int h, input int l, input int n, input int stopAt, input int mode,
                               output int firstRise, output int doneAt, output int rises,
                               output int falls, output logic [4:0] abortOut);
    int T, lastBusy, tail;
    logic prevWave;
    logic [4:0] got;
    T        = trainLen(h, l, n);
    lastBusy = (stopAt >= 1 && stopAt <= T) ? stopAt : T;
    tail     = (n == 0) ? 10 : 3;
    firstRise = -1;
    doneAt    = -1;
    rises     = 0;
    falls     = 0;
    abortOut  = 5'b00000;
    prevWave  = 1'b0;
    bus.iHighTime  = W'(h);
    bus.iLowTime   = W'(l);
    bus.iNumPulses = W'(n);
    bus.iStart     = 1'b1;
    bus.iStop      = 1'b0;
    for (int t = 1; t <= lastBusy + tail; t++) begin
      tick();
      got = sampleOut();
      checkOutput("train", t, got, refOut(h, l, n, t, stopAt));
      if (bus.oRise && firstRise < 0) firstRise = t;
      if (bus.oDone && doneAt < 0) doneAt = t;
      if (bus.oWave && !prevWave) rises++;
      if (!bus.oWave && prevWave) falls++;
      prevWave = bus.oWave;
      if (t == stopAt + 1) abortOut = got;
      bus.iStart = 1'b0;
      bus.iStop  = (t == stopAt);
      if (t <= lastBusy) begin
        if (mode == 1) begin
          bus.iStart     = 1'($urandom_range(0, 1));
          bus.iHighTime  = W'($urandom_range(0, 255));
          bus.iLowTime   = W'($urandom_range(0, 255));
          bus.iNumPulses = W'($urandom_range(0, 255));
        end else if (mode == 2 && t == 2) begin
          bus.iStart    = 1'b1;
          bus.iHighTime = W'(1);
        end
      end
    end
    bus.iStart = 1'b0;
    bus.iStop  = 1'b0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL timeout actual=running required=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    vec_t vecs[8];
    int fr, dn, ri, fa, len, h, l, n, st;
    logic [4:0] ab;

    vecs[0] = '{h: 3,   l: 2,   n: 2, expFirst: 1,  expLen: 8,   expRises: 2, expFalls: 2};
    vecs[1] = '{h: 0,   l: 0,   n: 3, expFirst: 1,  expLen: 5,   expRises: 3, expFalls: 3};
    vecs[2] = '{h: 1,   l: 1,   n: 1, expFirst: 1,  expLen: 1,   expRises: 1, expFalls: 1};
    vecs[3] = '{h: 0,   l: 7,   n: 0, expFirst: -1, expLen: -1,  expRises: 0, expFalls: 0};
    vecs[4] = '{h: 2,   l: 7,   n: 3, expFirst: 1,  expLen: 20,  expRises: 3, expFalls: 3};
    vecs[5] = '{h: 5,   l: 0,   n: 2, expFirst: 1,  expLen: 11,  expRises: 2, expFalls: 2};
    vecs[6] = '{h: 6,   l: 3,   n: 4, expFirst: 1,  expLen: 33,  expRises: 4, expFalls: 4};
    vecs[7] = '{h: 255, l: 0,   n: 2, expFirst: 1,  expLen: 511, expRises: 2, expFalls: 2};

    // Reset held with a start request pending: everything stays low.
    bus.iStart     = 1'b1;
    bus.iStop      = 1'b0;
    bus.iHighTime  = W'(2);
    bus.iLowTime   = W'(2);
    bus.iNumPulses = W'(3);
    iReset         = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      checkOutput("resetHold", i, sampleOut(), 5'b00000);
    end
    iReset     = 1'b0;
    bus.iStart = 1'b0;
    tick();
    checkOutput("resetRelease", 0, sampleOut(), 5'b00000);

    // Table of trains with hand-computed timing and edge counts.
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].h, vecs[i].l, vecs[i].n, 0, 0, fr, dn, ri, fa, ab);
      len = (fr >= 0 && dn >= 0) ? dn - fr : -1;
      checkValue($sformatf("vec%0d.firstRise", i), fr, vecs[i].expFirst);
      checkValue($sformatf("vec%0d.length", i), len, vecs[i].expLen);
      checkValue($sformatf("vec%0d.posEdges", i), ri, vecs[i].expRises);
      checkValue($sformatf("vec%0d.negEdges", i), fa, vecs[i].expFalls);
    end

    // Abort in the 3rd high cycle, then in a low cycle of the first gap.
    applyStimulus(5, 5, 4, 3, 0, fr, dn, ri, fa, ab);
    checkOutput("abortHigh", 4, ab, 5'b00100);
    checkValue("abortHigh.done", dn, -1);
    applyStimulus(5, 5, 4, 7, 0, fr, dn, ri, fa, ab);
    checkOutput("abortLow", 8, ab, 5'b00000);
    checkValue("abortLow.done", dn, -1);

    // Retrigger with new operands while busy has no effect.
    applyStimulus(4, 4, 2, 0, 2, fr, dn, ri, fa, ab);
    checkValue("busyProtect.length", dn - fr, 12);
    checkValue("busyProtect.posEdges", ri, 2);

    // Reset in the second high cycle of a long pulse: no fall, no done.
    bus.iHighTime  = W'(8);
    bus.iLowTime   = W'(1);
    bus.iNumPulses = W'(1);
    bus.iStart     = 1'b1;
    tick();
    bus.iStart = 1'b0;
    checkOutput("midReset.t1", 1, sampleOut(), 5'b11010);
    tick();
    checkOutput("midReset.t2", 2, sampleOut(), 5'b10010);
    iReset = 1'b1;
    tick();
    checkOutput("midReset.t3", 3, sampleOut(), 5'b00000);
    iReset = 1'b0;
    tick();
    checkOutput("midReset.t4", 4, sampleOut(), 5'b00000);
    applyStimulus(2, 1, 2, 0, 0, fr, dn, ri, fa, ab);
    checkValue("afterReset.length", dn - fr, 5);

    // Randomized trains with mid-train noise and occasional aborts.
    for (int k = 0; k < 40; k++) begin
      h  = $urandom_range(0, 6);
      l  = $urandom_range(0, 6);
      n  = $urandom_range(0, 4);
      st = 0;
      if (n != 0 && $urandom_range(0, 2) == 0) st = $urandom_range(1, trainLen(h, l, n));
      applyStimulus(h, l, n, st, 1, fr, dn, ri, fa, ab);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
